rib_arbiter: RTL and testbench
==============================

// Module: rib_arbiter
// PURPOSE
//  Shares one unified memory port (slave) between instruction fetch (m0, read-only) and EX load/store (m1).
//  Sits between ifetch/ex and the memory bus. Drives pipe_hold_o to freeze pc_reg/if_id while a fetch is pending.
//  Fixed priority to m1, with a starvation guard for m0 and a slave timeout that returns an error ack.
// PARAMETERS
//  AW          32   address width
//  DW          32   data width; strobe width is DW/8
//  STARVE_MAX  4    consecutive m1-wins while m0 waits before m0 is forced to win (>=1)
//  TIMEOUT     255  max BUSY cycles without s_ready_i before error abort (>=2)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async reset, active low
//  m0_req_i     in   1       fetch request; held until m0_ack_o
//  m0_addr_i    in   AW      fetch address
//  m0_ack_o     out  1       1-cycle completion pulse
//  m0_rdata_o   out  DW      fetch data, valid with m0_ack_o
//  m0_err_o     out  1       timeout error, valid with m0_ack_o
//  m1_req_i     in   1       load/store request; held until m1_ack_o
//  m1_we_i      in   1       1 = store
//  m1_addr_i    in   AW      data address
//  m1_wdata_i   in   DW      store data
//  m1_wstrb_i   in   DW/8    byte strobes
//  m1_ack_o     out  1       1-cycle completion pulse
//  m1_rdata_o   out  DW      load data, valid with m1_ack_o
//  m1_err_o     out  1       timeout error, valid with m1_ack_o
//  s_req_o      out  1       slave request, high for the whole BUSY state
//  s_we_o/s_addr_o/s_wdata_o/s_wstrb_o  out  1/AW/DW/DW/8  registered copy of the granted request
//  s_ready_i    in   1       slave done pulse; s_rdata_i valid with it
//  s_rdata_i    in   DW      slave read data
//  pipe_hold_o  out  1       = m0_req_i & ~m0_ack_o (combinational)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; starve_cnt, tmo_cnt and all s_* latches = 0; all acks/errs/rdata = 0.
//  FSM IDLE/BUSY_M0/BUSY_M1; the state register updates on the rising edge of clk.
//  IDLE arbitration (evaluated each cycle):
//    - only m0_req -> grant m0; only m1_req -> grant m1.
//    - both: grant m0 if starve_cnt==STARVE_MAX, else grant m1.
//    - on grant, latch we/addr/wdata/wstrb into s_* (m0: we=0, wstrb=all 1s); next state is BUSY_Mx.
//  starve_cnt: +1 when both request and m1 wins (saturates at STARVE_MAX); cleared when m0 is granted.
//  BUSY_Mx: s_req_o=1; s_* latches stay frozen even if master inputs change.
//    - s_ready_i=1 -> same cycle: mx_ack_o=1, mx_rdata_o=s_rdata_i, mx_err_o=0; next state IDLE.
//    - tmo_cnt counts BUSY cycles from 1. If tmo_cnt==TIMEOUT and s_ready_i=0 -> mx_ack_o=1, mx_err_o=1,
//      mx_rdata_o=0; next state IDLE. s_ready_i in the same cycle as the timeout wins (normal ack).
//  Latency: request seen in cycle 0 -> s_req_o from cycle 1 -> ack in the cycle s_ready_i arrives (min 1 cycle).
//    One IDLE cycle always separates transactions.
//  Acks and rdata are zero outside their completion cycle. The non-granted master's ack is never asserted.
//  s_ready_i while IDLE: ignored. A master dropping its req mid-BUSY: the transaction still completes and is acked.
//  Reset mid-BUSY: transaction dropped, no ack issued, s_req_o falls immediately.
//  tmo_cnt width = $clog2(TIMEOUT+1); starve_cnt width = $clog2(STARVE_MAX+1).
// STRUCTURE
//  Shared package riscv_defs: state encodings (ARB_IDLE/ARB_BUSY_M0/ARB_BUSY_M1) and default AW/DW.
//  Single module, no sub-module; both counters are inline, and the output mux is combinational from state.
// TESTING
//  1 m0 alone, addr 0x10; slave ready 2 cycles after s_req rises with rdata 0x00000013 -> s_req_o high in cycles 1-3;
//    m0_ack_o and rdata 0x13 in cycle 3; pipe_hold_o high in cycles 0-2, low in cycle 3.
//  2 m0 and m1 (load 0x200) request in the same cycle, starve_cnt=0 -> m1 served first; m0 granted in the IDLE cycle
//    after m1_ack_o; starve_cnt=1, then cleared.
//  3 m1 requests back-to-back, m0 held high, STARVE_MAX=4 -> m1 wins 4 arbitrations; m0 wins the 5th.
//  4 TIMEOUT=8, slave never ready on an m1 load -> m1_ack_o=1, m1_err_o=1, rdata=0 in BUSY cycle 8; IDLE next.
//    Repeat with s_ready_i in cycle 8 -> normal ack, err=0.
//  5 m1 store addr 0x100, wdata 0xDEADBEEF, wstrb 0xF; master changes addr/wdata during BUSY -> s_* stay 0x100/0xDEADBEEF.
//  6 rst_n low during BUSY_M1 -> s_req_o and acks 0 immediately, no ack; after release, IDLE and new request served.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared core definitions: default bus widths and the memory-port arbiter state encoding.
package riscv_defs;

  localparam int unsigned RIB_AW = 32;
  localparam int unsigned RIB_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_M0 = 2'd1,
    ARB_BUSY_M1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rib_arbiter.sv
// Unified memory-port arbiter: instruction fetch (m0) and load/store (m1) share one slave port.
// m1 has fixed priority, bounded by a starvation guard for m0; a stuck slave is aborted with an error ack.
module rib_arbiter
  import riscv_defs::*;
#(
  parameter int unsigned AW         = RIB_AW,
  parameter int unsigned DW         = RIB_DW,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req_i,
  input  logic [AW-1:0]   m0_addr_i,
  output logic            m0_ack_o,
  output logic [DW-1:0]   m0_rdata_o,
  output logic            m0_err_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_wstrb_i,
  output logic            m1_ack_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            m1_err_o,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_wstrb_o,
  input  logic            s_ready_i,
  input  logic [DW-1:0]   s_rdata_i,
  output logic            pipe_hold_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          s_we_q, s_we_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic [SW-1:0] s_wstrb_q, s_wstrb_d;

  logic busy;
  logic done_ok;
  logic done_tmo;
  logic grant_m0;
  logic grant_m1;

  // State, counters and the frozen copy of the granted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      starve_q  <= '0;
      tmo_q     <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_rdata_o = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_rdata_o = '0;

    busy     = (state_q != ARB_IDLE);
    done_ok  = busy & s_ready_i;
    // A ready pulse in the timeout cycle still counts as a normal completion
    done_tmo = busy & ~s_ready_i & (tmo_q == TW'(TIMEOUT));
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        grant_m0 = m0_req_i & (~m1_req_i | (starve_q == CW'(STARVE_MAX)));
        grant_m1 = m1_req_i & ~grant_m0;
        if (grant_m0) begin
          state_d   = ARB_BUSY_M0;
          starve_d  = '0;
          tmo_d     = TW'(1);
          s_we_d    = 1'b0;
          s_addr_d  = m0_addr_i;
          s_wdata_d = '0;
          s_wstrb_d = '1;
        end else if (grant_m1) begin
          state_d   = ARB_BUSY_M1;
          // m1 only beats a waiting m0 below STARVE_MAX, so this never overflows
          if (m0_req_i) starve_d = starve_q + CW'(1);
          tmo_d     = TW'(1);
          s_we_d    = m1_we_i;
          s_addr_d  = m1_addr_i;
          s_wdata_d = m1_wdata_i;
          s_wstrb_d = m1_wstrb_i;
        end
      end
      ARB_BUSY_M0, ARB_BUSY_M1: begin
        if (done_ok | done_tmo) begin
          state_d = ARB_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (state_q == ARB_BUSY_M0) begin
      m0_ack_o   = done_ok | done_tmo;
      m0_err_o   = done_tmo;
      m0_rdata_o = done_ok ? s_rdata_i : '0;
    end
    if (state_q == ARB_BUSY_M1) begin
      m1_ack_o   = done_ok | done_tmo;
      m1_err_o   = done_tmo;
      m1_rdata_o = done_ok ? s_rdata_i : '0;
    end
  end

  assign s_req_o     = busy;
  assign s_we_o      = s_we_q;
  assign s_addr_o    = s_addr_q;
  assign s_wdata_o   = s_wdata_q;
  assign s_wstrb_o   = s_wstrb_q;
  assign pipe_hold_o = m0_req_i & ~m0_ack_o;

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (ownership, win counting, reference memory).
module tb_rib_arbiter;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TIMEOUT    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0;
  logic [31:0]   m0_addr = '0;
  logic          m0_ack, m0_err;
  logic [31:0]   m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0]   m1_addr = '0, m1_wdata = '0;
  logic [3:0]    m1_wstrb = '0;
  logic          m1_ack, m1_err;
  logic [31:0]   m1_rdata;
  logic          s_req, s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_ready = 1'b0;
  logic [31:0]   s_rdata = '0;
  logic          pipe_hold;

  always #5 clk = ~clk;

  rib_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata), .pipe_hold_o(pipe_hold)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Model: owner 0 = idle, 1 = m0, 2 = m1; bcyc = BUSY cycle number from 1
  int owner = 0, bcyc = 0, dly = 0, force_dly = 0, wins = 0, cyc_n = 0;
  logic        rec_we;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_wstrb;
  bit m0_pend = 0, m1_pend = 0, rnd_en = 0, scr_en = 0, m1_auto = 0;
  int gnt_who[$], gnt_cyc[$], cmp_who[$], cmp_err[$], cmp_cyc[$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    return {24'h0, 6'($urandom_range(63, 0)), 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_m0(input logic [31:0] a);
    m0_req = 1'b1; m0_addr = a; m0_pend = 1;
  endtask

  task automatic issue_m1(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd; m1_wstrb = st; m1_pend = 1;
  endtask

  task automatic clear_logs();
    gnt_who.delete(); gnt_cyc.delete(); cmp_who.delete(); cmp_err.delete(); cmp_cyc.delete();
  endtask

  // One clock cycle: drive slave, check outputs mid-cycle, advance the model, react after the edge
  task automatic tick();
    logic rdy, dn_ok, dn_tmo, fin0, fin1;
    logic [31:0] exp_rd;
    int drop;
    if (scr_en && owner == 1) m0_addr = $urandom;
    if (scr_en && owner == 2) begin
      m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom); m1_we = ~m1_we;
    end
    rdy = (owner != 0) && (bcyc == dly);
    s_ready = rdy;
    s_rdata = rdy ? slv_rd(s_addr) : $urandom;
    @(negedge clk);
    dn_ok  = rdy;
    dn_tmo = (owner != 0) && !rdy && (bcyc == TIMEOUT);
    exp_rd = dn_ok ? ref_rd(rec_addr) : 32'h0;
    fin0 = (owner == 1) && (dn_ok || dn_tmo);
    fin1 = (owner == 2) && (dn_ok || dn_tmo);
    chk("s_req", s_req, owner != 0);
    if (owner != 0) begin
      chk("s_addr", s_addr, rec_addr);
      chk("s_we_strb", {s_we, s_wstrb}, {rec_we, rec_wstrb});
      if (owner == 2) chk("s_wdata", s_wdata, rec_wdata);
    end
    chk("m0_ack_err", {m0_ack, m0_err}, {fin0, fin0 && dn_tmo});
    chk("m0_rdata", m0_rdata, (owner == 1) ? exp_rd : 32'h0);
    chk("m1_ack_err", {m1_ack, m1_err}, {fin1, fin1 && dn_tmo});
    chk("m1_rdata", m1_rdata, (owner == 2) ? exp_rd : 32'h0);
    chk("pipe_hold", pipe_hold, m0_req && !fin0);
    drop = 0;
    if (owner != 0) begin
      if (dn_ok && s_we) slv_mem[s_addr] = merge(slv_rd(s_addr), s_wdata, s_wstrb);
      if (dn_ok || dn_tmo) begin
        if (dn_ok && rec_we) ref_mem[rec_addr] = merge(ref_rd(rec_addr), rec_wdata, rec_wstrb);
        cmp_who.push_back(owner); cmp_err.push_back(int'(dn_tmo)); cmp_cyc.push_back(cyc_n);
        drop = owner;
        owner = 0;
      end else begin
        bcyc++;
      end
    end else if (m0_pend || m1_pend) begin
      if (m0_pend && (!m1_pend || wins == STARVE_MAX)) begin
        owner = 1; wins = 0;
        rec_we = 1'b0; rec_addr = m0_addr; rec_wdata = 32'h0; rec_wstrb = 4'hF;
      end else begin
        owner = 2;
        if (m0_pend) wins++;
        rec_we = m1_we; rec_addr = m1_addr; rec_wdata = m1_wdata; rec_wstrb = m1_wstrb;
      end
      gnt_who.push_back(owner); gnt_cyc.push_back(cyc_n);
      bcyc = 1;
      dly = (force_dly > 0) ? force_dly : int'($urandom_range(10, 1));
    end
    cyc_n++;
    @(posedge clk); #1;
    s_ready = 1'b0;
    if (drop == 1) begin m0_req = 1'b0; m0_pend = 0; end
    if (drop == 2) begin
      m1_req = 1'b0; m1_pend = 0;
      if (m1_auto) issue_m1(1'b0, rand_addr(), 32'h0, 4'h0);
    end
    if (rnd_en) begin
      if (!m0_pend && $urandom_range(2, 0) == 0) issue_m0(rand_addr());
      if (!m1_pend && $urandom_range(3, 0) != 0)
        issue_m1(1'($urandom_range(1, 0)), rand_addr(), $urandom, 4'($urandom));
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((m0_pend || m1_pend || owner != 0) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_bound", {m0_pend, m1_pend, owner != 0}, 3'b000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_req", s_req, 1'b0);
    chk("rst_s_addr_wdata", {s_addr, s_wdata}, 64'h0);
    chk("rst_ctl", {s_we, s_wstrb, m0_ack, m0_err, m1_ack, m1_err}, 9'h0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 1: lone fetch, slave ready in the third BUSY cycle
    slv_mem[32'h10] = 32'h13; ref_mem[32'h10] = 32'h13;
    clear_logs(); force_dly = 3;
    n = cyc_n;
    issue_m0(32'h10);
    drain(20);
    chk("t1_count", cmp_who.size(), 1);
    chk("t1_who", cmp_who[0], 1);
    chk("t1_ack_cycle", cmp_cyc[0] - n, 3);

    // 2: simultaneous requests, m1 first, m0 in the IDLE cycle after m1's ack
    clear_logs(); force_dly = 2;
    issue_m0(32'h40);
    issue_m1(1'b0, 32'h200, 32'h0, 4'h0);
    drain(40);
    chk("t2_order", {gnt_who[0], gnt_who[1]}, {32'd2, 32'd1});
    chk("t2_gap", gnt_cyc[1] - cmp_cyc[0], 1);

    // 3: back-to-back m1 against a waiting m0
    clear_logs(); force_dly = 1; m1_auto = 1;
    issue_m0(32'h44);
    issue_m1(1'b0, 32'h204, 32'h0, 4'h0);
    n = 0;
    while (m0_pend && n < 100) begin tick(); n++; end
    m1_auto = 0;
    drain(50);
    chk("t3_ngrants", gnt_who.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++) chk("t3_grant", gnt_who[i], (i < 4) ? 2 : 1);

    // 4: slave timeout, then ready exactly in the timeout cycle
    clear_logs(); force_dly = 20;
    issue_m1(1'b0, 32'h80, 32'h0, 4'h0);
    drain(30);
    chk("t4_tmo_err", cmp_err[0], 1);
    chk("t4_tmo_cycle", cmp_cyc[0] - gnt_cyc[0], 8);
    clear_logs(); force_dly = 8;
    issue_m1(1'b0, 32'h80, 32'h0, 4'h0);
    drain(30);
    chk("t4_late_err", cmp_err[0], 0);
    chk("t4_late_cycle", cmp_cyc[0] - gnt_cyc[0], 8);

    // 5: store with master inputs changing during BUSY
    clear_logs(); force_dly = 4; scr_en = 1;
    issue_m1(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    drain(30);
    scr_en = 0;
    chk("t5_mem", slv_rd(32'h100), 32'hDEADBEEF);

    // 6: reset while m1 is in flight
    clear_logs(); force_dly = 20;
    issue_m1(1'b0, 32'h84, 32'h0, 4'h0);
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    chk("t6_s_req", s_req, 1'b0);
    chk("t6_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'h0);
    owner = 0; wins = 0; m1_req = 1'b0; m1_pend = 0;
    @(posedge clk); #1;
    chk("t6_s_req_held", s_req, 1'b0);
    rst_n = 1'b1;
    clear_logs(); force_dly = 2;
    issue_m1(1'b0, 32'h84, 32'h0, 4'h0);
    drain(20);
    chk("t6_after", {cmp_who.size(), cmp_who[0], cmp_err[0]}, {32'd1, 32'd2, 32'd0});
    force_dly = 0;

    // Random traffic
    rnd_en = 1; scr_en = 1;
    repeat (600) tick();
    rnd_en = 0; scr_en = 0;
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
